pipeline_hazard_ctrl: RTL and testbench

//  Central stall/flush sequencer for the VeSPA 5-stage pipeline (IF/ID, ID/EX, EX/MEM, MEM/WB regs).

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 32 +++
 rtl/pipeline_hazard_ctrl_if.sv | 48 ++++
 rtl/pipeline_hazard_ctrl_stall_counter.sv | 26 ++
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// pipeline_hazard_ctrl_pkg : shared state encodings and hazard helper
// Rev 1.0
// ============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        HZ_RUN      = 2'd0,
        HZ_MEM_WAIT = 2'd1,
        HZ_ABORT    = 2'd2
    } hz_state_e;

    // x0 is hard-wired to zero, so a load targeting it can never feed a consumer.
    function automatic logic load_use_hazard(
        input logic                  ex_load,
        input logic [REG_ADDR_W-1:0] ex_rd,
        input logic [REG_ADDR_W-1:0] rs1,
        input logic [REG_ADDR_W-1:0] rs2,
        input logic                  use_rs1,
        input logic                  use_rs2
    );
        return ex_load && (ex_rd != '0) &&
               ((use_rs1 && (rs1 == ex_rd)) || (use_rs2 && (rs2 == ex_rd)));
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_if.sv
// ============================================================================
// pipeline_hazard_ctrl_if : hazard inputs from the pipe, stall/flush controls back
// Rev 1.0
// ============================================================================
`default_nettype none

interface pipeline_hazard_ctrl_if
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_use_rs1;
    logic                  id_use_rs2;
    logic                  ex_rd_en_mem;
    logic [REG_ADDR_W-1:0] ex_ir_rst;
    logic                  ex_jmp_bit;
    logic                  mem_req;
    logic                  mem_ack;

    logic                  pc_hold;
    logic                  stall_if_id;
    logic                  stall_id_ex;
    logic                  stall_ex_mem;
    logic                  flush_if_id;
    logic                  flush_id_ex;
    logic                  flush_mem_wb;
    logic                  bus_err;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd_en_mem, ex_ir_rst,
               ex_jmp_bit, mem_req, mem_ack,
        input  pc_hold, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
               flush_id_ex, flush_mem_wb, bus_err, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd_en_mem, ex_ir_rst,
               ex_jmp_bit, mem_req, mem_ack,
        output pc_hold, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id,
               flush_id_ex, flush_mem_wb, bus_err, stall_cnt
    );

endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_stall_counter.sv
// ============================================================================
// pipeline_hazard_ctrl_stall_counter : saturating stalled-cycle counter
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl_stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// pipeline_hazard_ctrl : stall/flush sequencer for the 5-stage pipeline
// Rev 1.0
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int TO_W = $clog2(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    hz_state_e       state;
    hz_state_e       state_nxt;
    logic [TO_W-1:0] to_cnt;
    logic [TO_W-1:0] to_cnt_nxt;

    logic mem_stall;
    logic abort;
    logic load_use;
    logic pc_hold;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_mem_wb;
    logic bus_err;
    logic [CNT_W-1:0] stall_cnt;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state  <= HZ_RUN;
            to_cnt <= '0;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        to_cnt_nxt   = '0;
        mem_stall    = 1'b0;
        abort        = 1'b0;
        pc_hold      = 1'b0;
        stall_if_id  = 1'b0;
        stall_id_ex  = 1'b0;
        stall_ex_mem = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        flush_mem_wb = 1'b0;
        bus_err      = 1'b0;
        load_use     = load_use_hazard(bus.ex_rd_en_mem, bus.ex_ir_rst, bus.id_rs1,
                                       bus.id_rs2, bus.id_use_rs1, bus.id_use_rs2);

        case (state)
            HZ_RUN: begin
                if (bus.mem_req && !bus.mem_ack) begin
                    state_nxt = HZ_MEM_WAIT;
                    mem_stall = 1'b1;
                end
            end
            HZ_MEM_WAIT: begin
                if (bus.mem_ack) begin
                    state_nxt = HZ_RUN;
                end else begin
                    mem_stall = 1'b1;
                    if (to_cnt == TO_LAST) begin
                        state_nxt = HZ_ABORT;
                    end else begin
                        to_cnt_nxt = to_cnt + 1'b1;
                    end
                end
            end
            HZ_ABORT: begin
                state_nxt = HZ_RUN;
                abort     = 1'b1;
            end
            default: begin
                state_nxt = HZ_RUN;
            end
        endcase

        // A stalled EX/MEM keeps a resolved jump in EX, so its flush lands on the ack cycle.
        if (i_Rst) begin
            pc_hold = 1'b0;
        end else if (mem_stall) begin
            pc_hold      = 1'b1;
            stall_if_id  = 1'b1;
            stall_id_ex  = 1'b1;
            stall_ex_mem = 1'b1;
            flush_mem_wb = 1'b1;
        end else if (abort) begin
            bus_err      = 1'b1;
            flush_mem_wb = 1'b1;
        end else if (bus.ex_jmp_bit) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end else if (load_use) begin
            pc_hold     = 1'b1;
            stall_if_id = 1'b1;
            flush_id_ex = 1'b1;
        end
    end

    pipeline_hazard_ctrl_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .inc   (pc_hold),
        .count (stall_cnt)
    );

    assign bus.pc_hold      = pc_hold;
    assign bus.stall_if_id  = stall_if_id;
    assign bus.stall_id_ex  = stall_id_ex;
    assign bus.stall_ex_mem = stall_ex_mem;
    assign bus.flush_if_id  = flush_if_id;
    assign bus.flush_id_ex  = flush_id_ex;
    assign bus.flush_mem_wb = flush_mem_wb;
    assign bus.bus_err      = bus_err;
    assign bus.stall_cnt    = stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// tb_pipeline_hazard_ctrl : directed + random checks against a cycle model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

    localparam int MEM_TIMEOUT = 4;
    localparam int CNT_W       = 6;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    // Model state: how many consecutive cycles the current access has been stalled.
    int   m_age   = 0;
    bit   m_abort = 0;
    int   m_cnt   = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) ifc ();

    pipeline_hazard_ctrl #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst),
        .bus   (ifc)
    );

    function automatic logic [7:0] obs_vec();
        return {ifc.pc_hold, ifc.stall_if_id, ifc.stall_id_ex, ifc.stall_ex_mem,
                ifc.flush_if_id, ifc.flush_id_ex, ifc.flush_mem_wb, ifc.bus_err};
    endfunction

    function automatic bit model_stall();
        return (m_age > 0 || ifc.mem_req) && !ifc.mem_ack;
    endfunction

    // {pc_hold, stall_if_id, stall_id_ex, stall_ex_mem, flush_if_id, flush_id_ex, flush_mem_wb, bus_err}
    function automatic logic [7:0] model_out();
        bit ld_use;
        if (rst) return 8'b0000_0000;
        if (m_abort) return 8'b0000_0011;
        if (model_stall()) return 8'b1111_0010;
        if (ifc.ex_jmp_bit) return 8'b0000_1100;
        ld_use = ifc.ex_rd_en_mem && (ifc.ex_ir_rst != 0) &&
                 ((ifc.id_use_rs1 && ifc.id_rs1 == ifc.ex_ir_rst) ||
                  (ifc.id_use_rs2 && ifc.id_rs2 == ifc.ex_ir_rst));
        if (ld_use) return 8'b1100_0100;
        return 8'b0000_0000;
    endfunction

    task automatic model_step(input logic [7:0] exp);
        if (rst) begin
            m_age = 0; m_abort = 0; m_cnt = 0;
        end else begin
            if (exp[7] && m_cnt < CNT_MAX) m_cnt++;
            if (m_abort) begin
                m_abort = 0; m_age = 0;
            end else if (model_stall()) begin
                m_age++;
                if (m_age == MEM_TIMEOUT + 1) begin
                    m_abort = 1; m_age = 0;
                end
            end else begin
                m_age = 0;
            end
        end
    endtask

    task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkc(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic r, input logic ld, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic jmp,
                         input logic req, input logic ack);
        rst = r;
        ifc.ex_rd_en_mem = ld; ifc.ex_ir_rst = rd;
        ifc.id_rs1 = rs1; ifc.id_rs2 = rs2;
        ifc.id_use_rs1 = u1; ifc.id_use_rs2 = u2;
        ifc.ex_jmp_bit = jmp; ifc.mem_req = req; ifc.mem_ack = ack;
    endtask

    task automatic cycle(input string tag);
        logic [7:0] exp;
        exp = model_out();
        @(negedge clk);
        check8({tag, ".out"}, obs_vec(), exp);
        checkc({tag, ".cnt"}, ifc.stall_cnt, CNT_W'(m_cnt));
        @(posedge clk);
        model_step(exp);
        #1;
    endtask

    initial begin
        logic [CNT_W-1:0] base;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        cycle("reset");

        // load r3 in EX, ID add r4,r3,r1: one bubble then clean issue
        drive(0, 1, 3, 3, 1, 1, 1, 0, 0, 0);  cycle("lduse");
        drive(0, 0, 3, 3, 1, 1, 1, 0, 0, 0);  cycle("lduse_issue");

        // x0 destination never hazards
        drive(0, 1, 0, 0, 0, 1, 1, 0, 0, 0);  cycle("ld_x0");

        // access acked after 3 stall cycles
        base = ifc.stall_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
            cycle($sformatf("memwait%0d", i));
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);  cycle("memack");
        @(negedge clk);
        checkc("memwait_cnt_delta", ifc.stall_cnt, base + 3'd3);
        @(posedge clk); #1;

        // jump overrides load-use
        drive(0, 1, 5, 5, 0, 1, 0, 1, 0, 0);  cycle("jmp_over_lduse");

        // jump during mem stall deferred to ack cycle
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 0);  cycle("jmp_deferred");
        drive(0, 0, 0, 0, 0, 0, 0, 1, 1, 1);  cycle("jmp_on_ack");

        // never acked: abort on the 6th cycle counted from the request
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) cycle($sformatf("timeout%0d", i));
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check8("abort_cycle", obs_vec(), 8'b0000_0011);
        @(posedge clk); model_step(8'b0000_0011); #1;
        cycle("after_abort");

        // reset while waiting: back to RUN, no bus error
        drive(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle("pre_rst0"); cycle("pre_rst1");
        drive(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);  cycle("rst_in_wait");
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);  cycle("post_rst");

        // saturate the stall counter with a held load-use
        drive(0, 1, 7, 0, 7, 0, 1, 0, 0, 0);
        for (int i = 0; i < CNT_MAX + 6; i++) cycle($sformatf("sat%0d", i));
        @(negedge clk);
        checkc("stall_cnt_saturated", ifc.stall_cnt, '1);
        @(posedge clk); #1;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);  cycle("reset2");
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0));
            cycle($sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
